// File: rtl/product_block_array.sv
// product_block_array: multi-lane counting multiplier with temporal-code outputs.
// Each lane multiplies w_i by x_i with nested inner/outer counters (no multiplier).
// The running count is exposed on prod. out[i] carries either a unary pulse train
// (mode 0) or a single spike at the cycle the lane finishes (mode 1).
module product_block_array #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_rdy,
  input  logic                          mode,
  input  logic [CHANNELS*WIDTH-1:0]     w,
  input  logic [CHANNELS*WIDTH-1:0]     x,
  output logic                          busy,
  output logic [CHANNELS-1:0]           out,
  output logic [CHANNELS*2*WIDTH-1:0]   prod,
  output logic                          done
);

  // Product width; (2^WIDTH-1)^2 always fits, so counters never overflow.
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]    w_q     [CHANNELS];
  logic [WIDTH-1:0]    x_q     [CHANNELS];
  logic [WIDTH-1:0]    inner_q [CHANNELS];
  logic [WIDTH-1:0]    outer_q [CHANNELS];
  logic [PW-1:0]       prod_q  [CHANNELS];
  logic                mode_q;
  // Set once a lane has gone inactive in RUN, so the mode-1 spike fires only once.
  logic [CHANNELS-1:0] spiked_q;

  logic [CHANNELS-1:0] active;
  logic                accept;

  assign accept = (state_q == StIdle) && in_rdy;

  // Lane is still counting while outer < w and x is non-zero.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      active[i] = (outer_q[i] < w_q[i]) && (x_q[i] != '0);
    end
  end

  // Next-state logic: RUN ends on the first cycle where no lane is active (k = Pmax).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_rdy) state_d = StRun;
      StRun:   if (active == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture at accept; later operand changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
    end else if (accept) begin
      mode_q <= mode;
      for (int i = 0; i < CHANNELS; i++) begin
        w_q[i] <= w[i*WIDTH +: WIDTH];
        x_q[i] <= x[i*WIDTH +: WIDTH];
      end
    end
  end

  // Per-lane counting: inner wraps at x-1 and bumps outer; prod counts active cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spiked_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        inner_q[i] <= '0;
        outer_q[i] <= '0;
        prod_q[i]  <= '0;
      end
    end else if (accept) begin
      spiked_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        inner_q[i] <= '0;
        outer_q[i] <= '0;
        prod_q[i]  <= '0;
      end
    end else if (state_q == StRun) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (active[i]) begin
          prod_q[i] <= prod_q[i] + PW'(1);
          if (inner_q[i] == x_q[i] - WIDTH'(1)) begin
            inner_q[i] <= '0;
            outer_q[i] <= outer_q[i] + WIDTH'(1);
          end else begin
            inner_q[i] <= inner_q[i] + WIDTH'(1);
          end
        end else begin
          spiked_q[i] <= 1'b1;
        end
      end
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    out  = '0;
    if (state_q == StRun) begin
      for (int i = 0; i < CHANNELS; i++) begin
        // Mode 1: first inactive cycle of the lane is k == P_i.
        out[i] = mode_q ? (!active[i] && !spiked_q[i]) : active[i];
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      prod[i*PW +: PW] = prod_q[i];
    end
  end

endmodule

// File: tb/tb_product_block_array.sv
// Self-checking bench for product_block_array: vector table, randomized runs,
// async reset mid-run and back-to-back accepts with operands changing every cycle.
module tb_product_block_array;

  localparam int CH = 4;
  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_rdy;
  logic              mode;
  logic [CH*W-1:0]   w;
  logic [CH*W-1:0]   x;
  logic              busy;
  logic [CH-1:0]     out;
  logic [CH*PW-1:0]  prod;
  logic              done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_block_array #(
    .CHANNELS(CH),
    .WIDTH   (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .in_rdy(in_rdy),
    .mode  (mode),
    .w     (w),
    .x     (x),
    .busy  (busy),
    .out   (out),
    .prod  (prod),
    .done  (done)
  );

  typedef struct {
    logic [CH*W-1:0]  wv;
    logic [CH*W-1:0]  xv;
    logic             md;
    logic [CH*PW-1:0] exp_prod;
    int               exp_run;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: per-lane product from plain arithmetic.
  function automatic int lane_p(input logic [CH*W-1:0] wv, input logic [CH*W-1:0] xv,
                                input int i);
    return int'(wv[i*W +: W]) * int'(xv[i*W +: W]);
  endfunction

  function automatic logic [CH*PW-1:0] model_prod(input logic [CH*W-1:0] wv,
                                                  input logic [CH*W-1:0] xv);
    logic [CH*PW-1:0] r;
    for (int i = 0; i < CH; i++) r[i*PW +: PW] = PW'(lane_p(wv, xv, i));
    return r;
  endfunction

  // Called right after the accept edge; checks every RUN cycle and the DONE cycle.
  // Drives random operands every RUN cycle to show they are ignored.
  task automatic check_run(input logic [CH*W-1:0] wv, input logic [CH*W-1:0] xv,
                           input logic md, output int runlen);
    int               p [CH];
    int               pmax;
    int               c;
    logic [CH-1:0]    eo;
    logic [CH*PW-1:0] ep;
    pmax = 0;
    for (int i = 0; i < CH; i++) begin
      p[i] = lane_p(wv, xv, i);
      if (p[i] > pmax) pmax = p[i];
    end
    c = 0;
    @(negedge clk);
    while (busy === 1'b1 && c < 400) begin
      for (int i = 0; i < CH; i++) begin
        eo[i] = md ? (c == p[i]) : (c < p[i]);
        ep[i*PW +: PW] = PW'((c < p[i]) ? c : p[i]);
      end
      chk("run_out", 64'({done, out}), 64'({1'b0, eo}));
      chk("run_prod", 64'(prod), 64'(ep));
      w    = 16'($urandom);
      x    = 16'($urandom);
      mode = 1'($urandom);
      c++;
      @(negedge clk);
    end
    chk("run_len", 64'(c), 64'(pmax + 1));
    chk("done_flags", 64'({busy, done, out}), 64'({2'b01, {CH{1'b0}}}));
    chk("done_prod", 64'(prod), 64'(model_prod(wv, xv)));
    runlen = c;
  endtask

  // One isolated transaction starting from IDLE at a negedge.
  task automatic do_txn(input logic [CH*W-1:0] wv, input logic [CH*W-1:0] xv,
                        input logic md, output int runlen);
    w      = wv;
    x      = xv;
    mode   = md;
    in_rdy = 1'b1;
    @(posedge clk);
    #1 in_rdy = 1'b0;
    check_run(wv, xv, md, runlen);
    @(negedge clk);
    chk("idle_flags", 64'({busy, done, out}), 64'(0));
    chk("idle_prod_hold", 64'(prod), 64'(model_prod(wv, xv)));
  endtask

  function automatic logic [CH*W-1:0] small_ops();
    logic [CH*W-1:0] r;
    for (int i = 0; i < CH; i++) r[i*W +: W] = W'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    int               rl;
    logic [CH*W-1:0]  rw, rx, w1, x1, w2, x2;
    logic             m1, m2;

    tbl[0] = '{16'h0002, 16'h0001, 1'b0, 32'h0000_0002, 3};
    tbl[1] = '{16'h0023, 16'h0012, 1'b1, 32'h0000_0206, 7};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hE1E1_E1E1, 226};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 32'h0000_0000, 1};
    tbl[4] = '{16'h0000, 16'h0000, 1'b1, 32'h0000_0000, 1};
    tbl[5] = '{16'h1234, 16'h4321, 1'b1, 32'h0406_0604, 7};

    reset  = 1'b1;
    in_rdy = 1'b0;
    mode   = 1'b0;
    w      = '0;
    x      = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", 64'({busy, done, out, prod}), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 64'({busy, done, out, prod}), 64'(0));

    // Directed vectors.
    for (int t = 0; t < 6; t++) begin
      do_txn(tbl[t].wv, tbl[t].xv, tbl[t].md, rl);
      chk("tbl_run_len", 64'(rl), 64'(tbl[t].exp_run));
      chk("tbl_prod", 64'(prod), 64'(tbl[t].exp_prod));
    end

    // Randomized transactions against the arithmetic model.
    for (int t = 0; t < 20; t++) begin
      rw = 16'($urandom);
      rx = 16'($urandom);
      do_txn(rw, rx, 1'($urandom), rl);
    end

    // Async reset at k = 3 of a 4x4 run.
    w      = 16'h0004;
    x      = 16'h0004;
    mode   = 1'b0;
    in_rdy = 1'b1;
    @(posedge clk);
    #1 in_rdy = 1'b0;
    repeat (4) @(negedge clk);
    chk("k3_state", 64'({busy, done, out}), 64'({2'b10, 4'b0001}));
    chk("k3_prod", 64'(prod), 64'(3));
    #2 reset = 1'b1;
    #1 chk("async_reset", 64'({busy, done, out, prod}), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", 64'({busy, done, out, prod}), 64'(0));
    end
    do_txn(16'h0031, 16'h0023, 1'b1, rl);
    chk("fresh_run_len", 64'(rl), 64'(7));

    // Back-to-back with in_rdy held high and operands changing every cycle.
    w1 = small_ops();
    x1 = small_ops();
    m1 = 1'($urandom);
    w2 = small_ops();
    x2 = small_ops();
    m2 = ~m1;
    w      = w1;
    x      = x1;
    mode   = m1;
    in_rdy = 1'b1;
    @(posedge clk);
    #1 begin
      w    = 16'($urandom);
      x    = 16'($urandom);
      mode = 1'($urandom);
    end
    check_run(w1, x1, m1, rl);
    @(negedge clk);
    chk("b2b_idle", 64'({busy, done}), 64'(0));
    chk("b2b_idle_prod", 64'(prod), 64'(model_prod(w1, x1)));
    w    = w2;
    x    = x2;
    mode = m2;
    @(posedge clk);
    #1 begin
      w    = 16'($urandom);
      x    = 16'($urandom);
      mode = 1'($urandom);
    end
    check_run(w2, x2, m2, rl);
    in_rdy = 1'b0;
    @(negedge clk);
    chk("b2b_end_idle", 64'({busy, done, out}), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
